srff_flag_arbiter: RTL

- Bank of N sticky event flags, each with set-dominant SR flip-flop semantics, plus a round-robin arbiter that offers one pending flag at a time to a single service port.
- Uses a valid/ready handshake on that port. An accepted offer resets its flag.
- Sits between hardware event sources (set side) and a shared service engine or software status path (clear side).

---
 rtl/srff_arb_pkg.sv | 49 ++++
 rtl/srff_bank.sv | 45 ++++
 rtl/srff_flag_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/srff_arb_pkg.sv
// -----------------------------------------------------------------------------
// srff_arb_pkg
// Shared types and helpers for the sticky-flag round-robin arbiter.
//   arb_state_e : arbiter FSM states (IDLE, OFFER)
//   RR_MAX_N    : widest flag bank that rr_pick can search
//   rr_pick()   : round-robin search over an eligible vector, starting just
//                 above the last granted index and wrapping at n
// -----------------------------------------------------------------------------
package srff_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

  localparam int unsigned RR_MAX_N = 64;
  localparam int unsigned RR_IDX_W = $clog2(RR_MAX_N);

  // Returns the first set bit of eligible[n-1:0] found by searching upward
  // from (last_grant + 1) mod n with wrap-around. The last granted index is
  // visited last, so it only wins when nothing else is eligible. Returns 0
  // when nothing is eligible (callers only use the result when eligible != 0).
  // The loop has a constant bound so it unrolls into a fixed priority mux;
  // the wrap uses a subtract rather than a modulo since last_grant < n and
  // the step never exceeds n.
  function automatic int unsigned rr_pick(
    input logic [RR_MAX_N-1:0] eligible,
    input int unsigned         last_grant,
    input int unsigned         n
  );
    int unsigned cand;
    logic        found;
    rr_pick = 0;
    found   = 1'b0;
    for (int unsigned i = 1; i <= RR_MAX_N; i++) begin
      if (!found && (i <= n)) begin
        cand = last_grant + i;
        if (cand >= n) begin
          cand = cand - n;
        end
        if (eligible[cand[RR_IDX_W-1:0]]) begin
          rr_pick = cand;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/srff_bank.sv
// -----------------------------------------------------------------------------
// srff_bank
// N independent set-dominant SR flags with synchronous active-high reset.
// Ports:
//   clk     : clock
//   rst     : synchronous reset, clears every flag
//   set_i   : per-flag set (wins over clear and ack in the same cycle)
//   clr_i   : per-flag software clear
//   ack_i   : per-flag clear from an accepted service handshake
//   pend_o  : registered flag state
// -----------------------------------------------------------------------------
module srff_bank #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] set_i,
  input  logic [N-1:0] clr_i,
  input  logic [N-1:0] ack_i,
  output logic [N-1:0] pend_o
);

  logic [N-1:0] pend_q;
  logic [N-1:0] pend_d;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_flag
      // Set has priority so an event arriving in the same cycle as its
      // service completion is never lost.
      assign pend_d[gi] = set_i[gi] ? 1'b1 :
                          (clr_i[gi] | ack_i[gi]) ? 1'b0 : pend_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/srff_flag_arbiter.sv
// -----------------------------------------------------------------------------
// srff_flag_arbiter
// Bank of N sticky event flags plus a round-robin arbiter that offers one
// pending, unmasked flag at a time on a valid/ready service port. An accepted
// offer clears its flag (unless the flag is set again in that same cycle).
// Ports:
//   clk          : clock, all state changes on posedge
//   rst          : synchronous active-high reset
//   set_i        : per-flag set (pulse or level)
//   clr_i        : per-flag software clear
//   mask_i       : 1 = flag excluded from arbitration (still latches)
//   pend_o       : registered flag state, unaffected by mask_i
//   req_valid_o  : an offer is presented
//   req_id_o     : offered flag index, meaningful while req_valid_o = 1
//   req_ready_i  : service engine accepts the offer
//   busy_o       : FSM is in OFFER (same as req_valid_o)
// -----------------------------------------------------------------------------
module srff_flag_arbiter
  import srff_arb_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   set_i,
  input  logic [N-1:0]   clr_i,
  input  logic [N-1:0]   mask_i,
  output logic [N-1:0]   pend_o,
  output logic           req_valid_o,
  output logic [IDW-1:0] req_id_o,
  input  logic           req_ready_i,
  output logic           busy_o
);

  arb_state_e    state_q;
  logic          req_valid_q;
  logic [IDW-1:0] req_id_q;
  logic [IDW-1:0] last_grant_q;

  logic [N-1:0]        pend;
  logic [N-1:0]        ack;
  logic [N-1:0]        eligible;
  logic [RR_MAX_N-1:0] eligible_ext;
  logic [IDW-1:0]      pick_d;
  logic                accept;

  assign accept = req_valid_q & req_ready_i;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ack
      assign ack[gi] = accept & (req_id_q == IDW'(gi));
    end
  endgenerate

  srff_bank #(
    .N (N)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .set_i  (set_i),
    .clr_i  (clr_i),
    .ack_i  (ack),
    .pend_o (pend)
  );

  // Arbitration looks only at registered flags, never at set_i directly,
  // which is what gives the two-cycle set-to-offer latency.
  assign eligible     = pend & ~mask_i;
  assign eligible_ext = RR_MAX_N'(eligible);
  assign pick_d       = IDW'(rr_pick(eligible_ext, 32'(last_grant_q), N));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_valid_q  <= 1'b0;
      req_id_q     <= '0;
      last_grant_q <= IDW'(N - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (|eligible) begin
            req_id_q    <= pick_d;
            req_valid_q <= 1'b1;
            state_q     <= OFFER;
          end
        end
        OFFER: begin
          // Offers are never withdrawn: clearing or masking the offered flag
          // leaves the offer up until the service engine takes it.
          if (req_ready_i) begin
            last_grant_q <= req_id_q;
            req_valid_q  <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pend_o      = pend;
  assign req_valid_o = req_valid_q;
  assign req_id_o    = req_id_q;
  assign busy_o      = req_valid_q;

endmodule
